// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: pipeline control (stall/branch), program-load write port
// and the registered fetch outputs. The master side drives control and
// load signals. The slave side is the fetch unit itself.
interface instruction_fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  stall;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] instruction;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic                  valid;

  modport master (
    output stall, branch_taken, branch_target, load_en, load_addr, load_data,
    input  instruction, pc_out, valid
  );

  modport slave (
    input  stall, branch_taken, branch_target, load_en, load_addr, load_data,
    output instruction, pc_out, valid
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Single-cycle instruction fetch unit with an internal program memory.
// On each edge the word at PC is registered onto the fetch outputs and PC
// advances, with priority reset > branch > stall > fetch. A branch inserts
// exactly one bubble. The program-load port writes memory on any edge,
// including during reset. A fetch and a write to the same address in the
// same cycle return the old word.
module instruction_fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 10,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic                     clock,
  input logic                     reset,
  instruction_fetch_unit_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Program memory. It is never cleared, so contents are undefined until loaded.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [ADDR_WIDTH-1:0] pc_r;
  logic [DATA_WIDTH-1:0] instr_r;
  logic [ADDR_WIDTH-1:0] pc_out_r;
  logic                  valid_r;

  logic [ADDR_WIDTH-1:0] pc_next_s;
  logic [DATA_WIDTH-1:0] instr_next_s;
  logic [ADDR_WIDTH-1:0] pc_out_next_s;
  logic                  valid_next_s;
  logic [DATA_WIDTH-1:0] fetch_word_s;

  // The word at PC is read combinationally. The write below is non-blocking,
  // so a same-address write in the same cycle is not seen until the next fetch.
  assign fetch_word_s = mem_r[pc_r];

  // Program-load write port. It ignores reset, stall and branch.
  always_ff @(posedge clock) begin
    if (bus.load_en) begin
      mem_r[bus.load_addr] <= bus.load_data;
    end
  end

  // Next fetch state. A branch outranks a stall. PC increment wraps naturally.
  always_comb begin
    pc_next_s     = pc_r;
    instr_next_s  = instr_r;
    pc_out_next_s = pc_out_r;
    valid_next_s  = valid_r;
    if (bus.branch_taken) begin
      pc_next_s     = bus.branch_target;
      instr_next_s  = '0;
      pc_out_next_s = '0;
      valid_next_s  = 1'b0;
    end else if (bus.stall) begin
      pc_next_s     = pc_r;
      instr_next_s  = instr_r;
      pc_out_next_s = pc_out_r;
      valid_next_s  = valid_r;
    end else begin
      pc_next_s     = pc_r + ADDR_WIDTH'(1);
      instr_next_s  = fetch_word_s;
      pc_out_next_s = pc_r;
      valid_next_s  = 1'b1;
    end
  end

  // Fetch state registers. Synchronous reset overrides everything and drops
  // any fetch in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r     <= RESET_PC;
      instr_r  <= '0;
      pc_out_r <= '0;
      valid_r  <= 1'b0;
    end else begin
      pc_r     <= pc_next_s;
      instr_r  <= instr_next_s;
      pc_out_r <= pc_out_next_s;
      valid_r  <= valid_next_s;
    end
  end

  assign bus.instruction = instr_r;
  assign bus.pc_out      = pc_out_r;
  assign bus.valid       = valid_r;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001: Parameter DATA_WIDTH, default 10, instruction word width in bits.
REQ-002: Parameter ADDR_WIDTH, default 10, address width; memory depth is 2**ADDR_WIDTH words.
REQ-003: Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004: clock  input  1  single clock; all state updates on rising edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: stall  input  1  hold PC and fetch outputs this cycle.
REQ-007: branch_taken  input  1  redirect PC to branch_target and squash the in-flight fetch.
REQ-008: branch_target  input  ADDR_WIDTH  redirect address.
REQ-009: load_en  input  1  program-load write strobe.
REQ-010: load_addr  input  ADDR_WIDTH  program-load write address.
REQ-011: load_data  input  DATA_WIDTH  program-load write data.
REQ-012: instruction  output  DATA_WIDTH  registered fetched word.
REQ-013: pc_out  output  ADDR_WIDTH  address of the word on instruction.
REQ-014: valid  output  1  instruction/pc_out hold a live fetched word.

Function
REQ-015: Internal PC register (ADDR_WIDTH bits) and a 2**ADDR_WIDTH x DATA_WIDTH memory shall be implemented.
REQ-016: Per-edge priority shall be reset > branch_taken > stall > normal fetch.
REQ-017: Normal fetch: instruction <= mem[PC], pc_out <= PC, valid <= 1, PC <= PC+1.
REQ-018: Fetch latency shall be one cycle: word at address A appears on instruction the edge on which PC==A is consumed.
REQ-019: PC increment shall wrap modulo 2**ADDR_WIDTH (all-ones -> 0) with no flag or stall.
REQ-020: Stall (no branch): PC, instruction, pc_out, valid shall all hold previous values.
REQ-021: branch_taken: PC <= branch_target, instruction <= 0, pc_out <= 0, valid <= 0, regardless of stall.
REQ-022: Cycle after a branch (no stall) shall fetch mem[branch_target] with valid=1; branch penalty is exactly one bubble.
REQ-023: Back-to-back branch_taken shall keep valid=0 and redirect PC to each newest target.
REQ-024: load_en shall write mem[load_addr] <= load_data on the edge, independent of stall, branch_taken and reset.
REQ-025: Read-during-write to the same address shall be read-first: fetch returns old contents; new contents visible on next fetch of that address.
REQ-026: Memory contents shall not be cleared by reset and are undefined until loaded.

Reset
REQ-027: On reset edge: PC <= RESET_PC, instruction <= 0, pc_out <= 0, valid <= 0.
REQ-028: Reset shall override stall and branch_taken; a fetch in progress is discarded.
REQ-029: First edge with reset low and no stall/branch shall present mem[RESET_PC] with valid=1, pc_out=RESET_PC.
REQ-030: Reset asserted mid-stream shall take effect on the next edge with no partial update.

Verification
REQ-031: Load mem[0..3]=10'h001,10'h002,10'h003,10'h004, release reset -> instruction 001,002,003,004 on four consecutive edges, pc_out 0..3, valid=1.
REQ-032: Stall held 3 cycles while instruction=10'h002, pc_out=1 -> outputs unchanged 3 cycles; next edge instruction=10'h003, pc_out=2.
REQ-033: branch_taken with branch_target=10'h200 while mem[10'h200]=10'h155 -> next edge valid=0, instruction=0; following edge instruction=10'h155, pc_out=10'h200, valid=1.
REQ-034: branch_taken and stall together, target 10'h3FF -> branch wins; after bubble pc_out=10'h3FF, then pc_out=10'h000 (wrap).
REQ-035: load_en to address 5 on the edge fetching address 5 (old 10'h0AA, new 10'h155) -> old 10'h0AA returned; branch to 5 then returns 10'h155.
REQ-036: Reset asserted mid-stream at pc_out=10'h010, RESET_PC=10'h020 -> next edge valid=0, pc_out=0; first edge after release instruction=mem[10'h020], pc_out=10'h020.
